avalon_xbar_arbiter: RTL

Per-slave round-robin arbiter that produces the select bus for the 5x5 Avalon crossbar mux.
- Each master presents a decoded target-slave index. For each slave, the block grants one requesting master and holds the grant until that master's burst completes.
- It stalls every requesting master that does not hold a grant.
- It sits between the address decoders and the crossbar mux select input.

---
 rtl/avalon_xbar_pkg.sv | 18 +
 rtl/avalon_xbar_rr_slot.sv | 116 +++++++++++
 rtl/avalon_xbar_arbiter.sv | 62 ++++++
 3 files changed

// File: rtl/avalon_xbar_pkg.sv
// Shared parameters and types for the 5x5 Avalon crossbar.
// Used by the per-slave arbiter and the crossbar mux.
package avalon_xbar_pkg;

    localparam int NUM_INPUTS  = 5;
    localparam int NUM_OUTPUTS = 5;
    localparam int SEL_W       = $clog2(NUM_INPUTS + 1);
    localparam int TGT_W       = 3;
    localparam int BC_W        = 8;

    localparam logic [SEL_W-1:0] IDLE_SEL = SEL_W'(NUM_INPUTS);

    typedef enum logic {
        IDLE,
        ACTIVE
    } slot_state_e;

endpackage

// File: rtl/avalon_xbar_rr_slot.sv
// One slave slot: round-robin pick, burst beat counter, locked select.
// Select shows IDLE_SEL whenever the slot is not ACTIVE.
module avalon_xbar_rr_slot
    import avalon_xbar_pkg::*;
(
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic [NUM_INPUTS-1:0]        i_Req,
    input  logic [NUM_INPUTS-1:0]        i_Busy,
    input  logic [BC_W*NUM_INPUTS-1:0]   i_BurstCount,
    input  logic                         i_WaitRequest,
    output logic [SEL_W-1:0]             o_Sel
);

    slot_state_e      r_State;
    logic [SEL_W-1:0] r_Sel;
    logic [SEL_W-1:0] r_Ptr;
    logic [BC_W-1:0]  r_Cnt;

    slot_state_e      w_StateNxt;
    logic [SEL_W-1:0] w_SelNxt;
    logic [SEL_W-1:0] w_PtrNxt;
    logic [BC_W-1:0]  w_CntNxt;

    logic             w_FoundHi;
    logic             w_FoundLo;
    logic [SEL_W-1:0] w_WinHi;
    logic [SEL_W-1:0] w_WinLo;
    logic             w_Found;
    logic [SEL_W-1:0] w_Winner;
    logic [BC_W-1:0]  w_WinBc;
    logic             w_GntBusy;
    logic             w_Beat;

    // Two descending scans: at/above the pointer first, then wrap to 0.
    always_comb begin
        w_FoundHi = 1'b0;
        w_FoundLo = 1'b0;
        w_WinHi   = '0;
        w_WinLo   = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (i_Req[i] && (SEL_W'(i) >= r_Ptr)) begin
                w_FoundHi = 1'b1;
                w_WinHi   = SEL_W'(i);
            end
            if (i_Req[i]) begin
                w_FoundLo = 1'b1;
                w_WinLo   = SEL_W'(i);
            end
        end
        w_Found  = w_FoundHi | w_FoundLo;
        w_Winner = w_FoundHi ? w_WinHi : w_WinLo;
    end

    always_comb begin
        w_WinBc   = '0;
        w_GntBusy = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (SEL_W'(i) == w_Winner)
                w_WinBc = i_BurstCount[i*BC_W +: BC_W];
            if (SEL_W'(i) == r_Sel)
                w_GntBusy = i_Busy[i];
        end
        w_Beat = (r_State == ACTIVE) && w_GntBusy && !i_WaitRequest;
    end

    always_comb begin
        w_StateNxt = r_State;
        w_SelNxt   = r_Sel;
        w_PtrNxt   = r_Ptr;
        w_CntNxt   = r_Cnt;
        unique case (r_State)
            IDLE: begin
                if (w_Found) begin
                    w_StateNxt = ACTIVE;
                    w_SelNxt   = w_Winner;
                    w_PtrNxt   = (w_Winner == SEL_W'(NUM_INPUTS - 1)) ?
                                 '0 : w_Winner + 1'b1;
                    w_CntNxt   = (w_WinBc == '0) ? BC_W'(1) : w_WinBc;
                end
            end
            ACTIVE: begin
                if (w_Beat) begin
                    if (r_Cnt > BC_W'(1)) begin
                        w_CntNxt = r_Cnt - 1'b1;
                    end else begin
                        w_StateNxt = IDLE;
                        w_SelNxt   = IDLE_SEL;
                        w_CntNxt   = '0;
                    end
                end
            end
            default: begin
                w_StateNxt = IDLE;
                w_SelNxt   = IDLE_SEL;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= IDLE;
            r_Sel   <= IDLE_SEL;
            r_Ptr   <= '0;
            r_Cnt   <= '0;
        end else begin
            r_State <= w_StateNxt;
            r_Sel   <= w_SelNxt;
            r_Ptr   <= w_PtrNxt;
            r_Cnt   <= w_CntNxt;
        end
    end

    assign o_Sel = r_Sel;

endmodule

// File: rtl/avalon_xbar_arbiter.sv
// Per-slave round-robin arbiter driving the 5x5 crossbar mux select.
// Decodes master targets into per-slot requests and builds master stalls.
module avalon_xbar_arbiter
    import avalon_xbar_pkg::*;
(
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic [TGT_W*NUM_INPUTS-1:0]  i_Target,
    input  logic [NUM_INPUTS-1:0]        i_AVIn_Read,
    input  logic [NUM_INPUTS-1:0]        i_AVIn_Write,
    input  logic [BC_W*NUM_INPUTS-1:0]   i_AVIn_BurstCount,
    input  logic [NUM_OUTPUTS-1:0]       i_AVOut_WaitRequest,
    output logic [SEL_W*NUM_OUTPUTS-1:0] o_MuxSel,
    output logic [NUM_INPUTS-1:0]        o_AVIn_Hold
);

    logic [NUM_INPUTS-1:0] w_Busy;
    logic [NUM_INPUTS-1:0] w_Valid;
    logic [NUM_INPUTS-1:0] w_Granted;
    logic [NUM_INPUTS-1:0] w_Req [NUM_OUTPUTS];
    logic [SEL_W-1:0]      w_Sel [NUM_OUTPUTS];

    assign w_Busy = i_AVIn_Read | i_AVIn_Write;

    // Out-of-range targets never reach a slot and never stall the master.
    always_comb begin
        w_Valid = '0;
        for (int j = 0; j < NUM_OUTPUTS; j++)
            w_Req[j] = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_Valid[i] = w_Busy[i] &&
                (i_Target[i*TGT_W +: TGT_W] < TGT_W'(NUM_OUTPUTS));
            for (int j = 0; j < NUM_OUTPUTS; j++)
                w_Req[j][i] = w_Busy[i] &&
                    (i_Target[i*TGT_W +: TGT_W] == TGT_W'(j));
        end
    end

    for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_slot
        avalon_xbar_rr_slot u_slot (
            .i_Clk         (i_Clk),
            .i_Reset       (i_Reset),
            .i_Req         (w_Req[j]),
            .i_Busy        (w_Busy),
            .i_BurstCount  (i_AVIn_BurstCount),
            .i_WaitRequest (i_AVOut_WaitRequest[j]),
            .o_Sel         (w_Sel[j])
        );
        assign o_MuxSel[j*SEL_W +: SEL_W] = w_Sel[j];
    end

    always_comb begin
        w_Granted = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            for (int j = 0; j < NUM_OUTPUTS; j++)
                if (w_Sel[j] == SEL_W'(i))
                    w_Granted[i] = 1'b1;
    end

    assign o_AVIn_Hold = w_Valid & ~w_Granted;

endmodule
